// File: rtl/ram_2port_sync_if.sv
// Bus bundle for ram_2port_sync: one write port and one read port sharing a clock.
// The master drives addresses, enables and write data; the RAM returns read data and valid.
interface ram_2port_sync_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 256
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    i_wr_addr;
  logic             i_wr_dv;
  logic [WIDTH-1:0] i_wr_data;
  logic [AW-1:0]    i_rd_addr;
  logic             i_rd_en;
  logic             o_rd_dv;
  logic [WIDTH-1:0] o_rd_data;

  modport master (
    output i_wr_addr, i_wr_dv, i_wr_data, i_rd_addr, i_rd_en,
    input  o_rd_dv, o_rd_data
  );

  modport slave (
    input  i_wr_addr, i_wr_dv, i_wr_data, i_rd_addr, i_rd_en,
    output o_rd_dv, o_rd_data
  );
endinterface

// File: rtl/ram_2port_sync.sv
// Simple dual-port RAM with synchronous write and one-cycle registered read plus valid strobe.
// Define RAM_2PORT_SYNC_WR_FWD_EN for write-first collision forwarding; default is read-first.
module ram_2port_sync #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 256
) (
  input  logic            i_clk,
  input  logic            i_rst,
  ram_2port_sync_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_in_range;
  logic             rd_in_range;
  logic [WIDTH-1:0] rd_word;

  // Only matters for non-power-of-two depths, where the address can exceed the array.
  assign wr_in_range = int'({1'b0, bus.i_wr_addr}) < DEPTH;
  assign rd_in_range = int'({1'b0, bus.i_rd_addr}) < DEPTH;

  // Storage is deliberately not reset so it maps onto block RAM.
  always_ff @(posedge i_clk) begin
    if (!i_rst && bus.i_wr_dv && wr_in_range) begin
      mem[bus.i_wr_addr] <= bus.i_wr_data;
    end
  end

  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
`ifdef RAM_2PORT_SYNC_WR_FWD_EN
      if (bus.i_wr_dv && (bus.i_wr_addr == bus.i_rd_addr)) begin
        rd_word = bus.i_wr_data;
      end else begin
        rd_word = mem[bus.i_rd_addr];
      end
`else
      rd_word = mem[bus.i_rd_addr];
`endif
    end
  end

  // Read data holds its last value whenever no request is made.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bus.o_rd_dv   <= 1'b0;
      bus.o_rd_data <= '0;
    end else begin
      bus.o_rd_dv <= bus.i_rd_en;
      if (bus.i_rd_en) begin
        bus.o_rd_data <= rd_word;
      end
    end
  end

  logic [AW-1:0] unused_aw;
  assign unused_aw = '0;
endmodule

// File: tb/tb_ram_2port_sync.sv
// Directed self-checking bench for ram_2port_sync: a 4x8 instance for the main
// behaviour and a 5x8 instance for out-of-range addressing.
module tb_ram_2port_sync;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fails;

  ram_2port_sync_if #(.WIDTH(8), .DEPTH(4)) bus ();
  ram_2port_sync_if #(.WIDTH(8), .DEPTH(5)) bus5 ();

  ram_2port_sync #(.WIDTH(8), .DEPTH(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  ram_2port_sync #(.WIDTH(8), .DEPTH(5)) dut5 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.i_wr_dv   = 1'b0;
    bus.i_rd_en   = 1'b0;
    bus5.i_wr_dv  = 1'b0;
    bus5.i_rd_en  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.i_wr_addr = '0;  bus.i_wr_data = '0;  bus.i_rd_addr = '0;
    bus5.i_wr_addr = '0; bus5.i_wr_data = '0; bus5.i_rd_addr = '0;
    idle();
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (bus.o_rd_dv !== 1'b0) begin
      n_fails++; $display("[TB] FAIL reset_dv got %b want 0", bus.o_rd_dv);
    end
    n_checks++;
    if (bus.o_rd_data !== 8'h00) begin
      n_fails++; $display("[TB] FAIL reset_data got %h want 00", bus.o_rd_data);
    end
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_fill_read();
    for (int i = 0; i < 4; i++) begin
      bus.i_wr_dv   = 1'b1;
      bus.i_wr_addr = 2'(i);
      bus.i_wr_data = 8'(i);
      tick();
    end
    bus.i_wr_dv = 1'b0;
    n_checks++;
    if (bus.o_rd_dv !== 1'b0) begin
      n_fails++; $display("[TB] FAIL fill_dv_idle got %b want 0", bus.o_rd_dv);
    end
    for (int i = 0; i < 4; i++) begin
      bus.i_rd_en   = 1'b1;
      bus.i_rd_addr = 2'(i);
      tick();
      n_checks++;
      if (bus.o_rd_dv !== 1'b1) begin
        n_fails++; $display("[TB] FAIL fill_dv[%0d] got %b want 1", i, bus.o_rd_dv);
      end
      n_checks++;
      if (bus.o_rd_data !== 8'(i)) begin
        n_fails++; $display("[TB] FAIL fill_data[%0d] got %h want %h", i, bus.o_rd_data, 8'(i));
      end
    end
  endtask

  task automatic test_hold();
    bus.i_rd_en   = 1'b0;
    bus.i_rd_addr = 2'd0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (bus.o_rd_dv !== 1'b0) begin
        n_fails++; $display("[TB] FAIL hold_dv[%0d] got %b want 0", i, bus.o_rd_dv);
      end
      n_checks++;
      if (bus.o_rd_data !== 8'd3) begin
        n_fails++; $display("[TB] FAIL hold_data[%0d] got %h want 03", i, bus.o_rd_data);
      end
    end
  endtask

  task automatic test_collision();
    logic [7:0] exp_first;
`ifdef RAM_2PORT_SYNC_WR_FWD_EN
    exp_first = 8'd84;
`else
    exp_first = 8'd1;
`endif
    bus.i_wr_dv   = 1'b1;
    bus.i_wr_addr = 2'd1;
    bus.i_wr_data = 8'd84;
    bus.i_rd_en   = 1'b1;
    bus.i_rd_addr = 2'd1;
    tick();
    idle();
    n_checks++;
    if (bus.o_rd_data !== exp_first) begin
      n_fails++; $display("[TB] FAIL collision_first got %h want %h", bus.o_rd_data, exp_first);
    end
    tick();
    tick();
    bus.i_rd_en   = 1'b1;
    bus.i_rd_addr = 2'd1;
    tick();
    bus.i_rd_en = 1'b0;
    n_checks++;
    if (bus.o_rd_data !== 8'd84) begin
      n_fails++; $display("[TB] FAIL collision_later got %h want 54", bus.o_rd_data);
    end
  endtask

  task automatic test_independent();
    bus.i_wr_dv   = 1'b1;
    bus.i_wr_addr = 2'd2;
    bus.i_wr_data = 8'hAA;
    bus.i_rd_en   = 1'b1;
    bus.i_rd_addr = 2'd0;
    tick();
    bus.i_wr_dv = 1'b0;
    n_checks++;
    if (bus.o_rd_data !== 8'h00) begin
      n_fails++; $display("[TB] FAIL indep_rd0 got %h want 00", bus.o_rd_data);
    end
    bus.i_rd_addr = 2'd2;
    tick();
    bus.i_rd_en = 1'b0;
    n_checks++;
    if (bus.o_rd_data !== 8'hAA) begin
      n_fails++; $display("[TB] FAIL indep_rd2 got %h want aa", bus.o_rd_data);
    end
  endtask

  task automatic test_reset_mid();
    bus.i_rd_en   = 1'b1;
    bus.i_rd_addr = 2'd3;
    tick();
    // read request stays asserted into the cycle where reset arrives
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if (bus.o_rd_dv !== 1'b0) begin
      n_fails++; $display("[TB] FAIL midrst_dv got %b want 0", bus.o_rd_dv);
    end
    n_checks++;
    if (bus.o_rd_data !== 8'h00) begin
      n_fails++; $display("[TB] FAIL midrst_data got %h want 00", bus.o_rd_data);
    end
    bus.i_wr_dv   = 1'b1;
    bus.i_wr_addr = 2'd0;
    bus.i_wr_data = 8'h55;
    tick();
    n_checks++;
    if (bus.o_rd_dv !== 1'b0) begin
      n_fails++; $display("[TB] FAIL midrst_drop got %b want 0", bus.o_rd_dv);
    end
    idle();
    rst = 1'b0;
    bus.i_rd_en   = 1'b1;
    bus.i_rd_addr = 2'd0;
    tick();
    n_checks++;
    if (bus.o_rd_data !== 8'h00) begin
      n_fails++; $display("[TB] FAIL rst_write_ignored got %h want 00", bus.o_rd_data);
    end
    bus.i_rd_addr = 2'd2;
    tick();
    bus.i_rd_en = 1'b0;
    n_checks++;
    if (bus.o_rd_data !== 8'hAA) begin
      n_fails++; $display("[TB] FAIL rst_persist got %h want aa", bus.o_rd_data);
    end
  endtask

  task automatic test_range();
    logic [2:0] waddr [4] = '{3'd1, 3'd4, 3'd5, 3'd7};
    logic [7:0] wdata [4] = '{8'h11, 8'h44, 8'h99, 8'h77};
    logic [7:0] rexp  [4] = '{8'h11, 8'h44, 8'h00, 8'h00};
    for (int i = 0; i < 4; i++) begin
      bus5.i_wr_dv   = 1'b1;
      bus5.i_wr_addr = waddr[i];
      bus5.i_wr_data = wdata[i];
      tick();
    end
    bus5.i_wr_dv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus5.i_rd_en   = 1'b1;
      bus5.i_rd_addr = waddr[i];
      tick();
      n_checks++;
      if (bus5.o_rd_dv !== 1'b1) begin
        n_fails++; $display("[TB] FAIL range_dv[%0d] got %b want 1", waddr[i], bus5.o_rd_dv);
      end
      n_checks++;
      if (bus5.o_rd_data !== rexp[i]) begin
        n_fails++; $display("[TB] FAIL range_data[%0d] got %h want %h", waddr[i], bus5.o_rd_data, rexp[i]);
      end
    end
    bus5.i_rd_en = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    test_reset();
    test_fill_read();
    test_hold();
    test_collision();
    test_independent();
    test_reset_mid();
    test_range();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
